// File: rtl/timer0_pwm_pkg.sv
// Shared constants, encodings and helpers for Timer/Counter0.
package timer0_pwm_pkg;

    localparam int T0_DW = 8;
    localparam int T0_AW = 6;

    localparam logic [5:0] T0_TCCR0A = 6'h24;
    localparam logic [5:0] T0_TCCR0B = 6'h25;
    localparam logic [5:0] T0_TCNT0  = 6'h26;
    localparam logic [5:0] T0_OCR0A  = 6'h27;
    localparam logic [5:0] T0_OCR0B  = 6'h28;
    localparam logic [5:0] T0_TIFR0  = 6'h38;
    localparam logic [5:0] T0_TIMSK0 = 6'h39;

    localparam logic [2:0] WGM_NORMAL   = 3'd0;
    localparam logic [2:0] WGM_PC_FF    = 3'd1;
    localparam logic [2:0] WGM_CTC      = 3'd2;
    localparam logic [2:0] WGM_FAST_FF  = 3'd3;
    localparam logic [2:0] WGM_PC_OCR   = 3'd5;
    localparam logic [2:0] WGM_FAST_OCR = 3'd7;

    localparam logic [1:0] COM_OFF    = 2'b00;
    localparam logic [1:0] COM_TOGGLE = 2'b01;
    localparam logic [1:0] COM_CLEAR  = 2'b10;
    localparam logic [1:0] COM_SET    = 2'b11;

    localparam logic [2:0] CS_STOP    = 3'd0;
    localparam logic [2:0] CS_DIV1    = 3'd1;
    localparam logic [2:0] CS_DIV8    = 3'd2;
    localparam logic [2:0] CS_DIV64   = 3'd3;
    localparam logic [2:0] CS_DIV256  = 3'd4;
    localparam logic [2:0] CS_DIV1024 = 3'd5;

    // Same bit positions in TIFR0 and TIMSK0
    localparam int BIT_TOV0  = 0;
    localparam int BIT_OCF0A = 1;
    localparam int BIT_OCF0B = 2;

    typedef enum logic [1:0] {
        MODE_NORMAL,
        MODE_CTC,
        MODE_FAST,
        MODE_PC
    } mode_t;

    function automatic mode_t wgm_mode(input logic [2:0] wgm);
        case (wgm)
            WGM_NORMAL:                return MODE_NORMAL;
            WGM_CTC:                   return MODE_CTC;
            WGM_FAST_FF, WGM_FAST_OCR: return MODE_FAST;
            WGM_PC_FF, WGM_PC_OCR:     return MODE_PC;
            default:                   return MODE_NORMAL;
        endcase
    endfunction

    function automatic logic wgm_top_ocr(input logic [2:0] wgm);
        return wgm == WGM_CTC || wgm == WGM_PC_OCR ||
               wgm == WGM_FAST_OCR;
    endfunction

    // Match action takes priority over the wrap action
    function automatic logic oc_next(
        input logic       cur,
        input logic [1:0] com,
        input mode_t      mode,
        input logic       match,
        input logic       wrap,
        input logic       down
    );
        logic r;
        r = cur;
        if (com == COM_OFF) begin
            r = 1'b0;
        end else if (match) begin
            case (com)
                COM_TOGGLE: r = ~cur;
                COM_CLEAR:  r = (mode == MODE_PC) && down;
                default:    r = !((mode == MODE_PC) && down);
            endcase
        end else if (wrap && mode == MODE_FAST) begin
            if (com == COM_CLEAR)
                r = 1'b1;
            else if (com == COM_SET)
                r = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/timer0_pwm_if.sv
// I/O-space register bus between the core and Timer/Counter0.
interface timer0_pwm_if
    import timer0_pwm_pkg::*;
#(
    parameter int AW = T0_AW,
    parameter int DW = T0_DW
);
    logic [AW-1:0] io_addr;
    logic          io_wr;
    logic          io_rd;
    logic [DW-1:0] io_din;
    logic [DW-1:0] io_dout;

    modport master (
        output io_addr, io_wr, io_rd, io_din,
        input  io_dout
    );

    modport slave (
        input  io_addr, io_wr, io_rd, io_din,
        output io_dout
    );
endinterface

// File: rtl/timer0_prescaler.sv
// Clock prescaler: turns the CS select into a count-enable tick.
module timer0_prescaler
    import timer0_pwm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] cs,
    output logic       tick
);
    logic [9:0] cnt;
    logic       run;

    // External-clock selects are treated as stopped
    assign run = cs != CS_STOP && cs <= CS_DIV1024;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (!run)
            cnt <= '0;
        else
            cnt <= cnt + 10'd1;
    end

    always_comb begin
        tick = 1'b0;
        unique case (cs)
            CS_DIV1:    tick = 1'b1;
            CS_DIV8:    tick = &cnt[2:0];
            CS_DIV64:   tick = &cnt[5:0];
            CS_DIV256:  tick = &cnt[7:0];
            CS_DIV1024: tick = &cnt;
            default:    tick = 1'b0;
        endcase
    end
endmodule

// File: rtl/timer0_pwm.sv
// 8-bit Timer/Counter0 with two compare outputs and an AVR-style register map.
module timer0_pwm
    import timer0_pwm_pkg::*;
#(
    parameter int DATA_WIDTH    = T0_DW,
    parameter int IO_ADDR_WIDTH = T0_AW,
    parameter logic [IO_ADDR_WIDTH-1:0] ADDR_TCCR0A = T0_TCCR0A,
    parameter logic [IO_ADDR_WIDTH-1:0] ADDR_TCCR0B = T0_TCCR0B,
    parameter logic [IO_ADDR_WIDTH-1:0] ADDR_TCNT0  = T0_TCNT0,
    parameter logic [IO_ADDR_WIDTH-1:0] ADDR_OCR0A  = T0_OCR0A,
    parameter logic [IO_ADDR_WIDTH-1:0] ADDR_OCR0B  = T0_OCR0B,
    parameter logic [IO_ADDR_WIDTH-1:0] ADDR_TIMSK0 = T0_TIMSK0,
    parameter logic [IO_ADDR_WIDTH-1:0] ADDR_TIFR0  = T0_TIFR0
) (
    input  logic        clk,
    input  logic        reset,
    timer0_pwm_if.slave io,
    output logic        oc0a,
    output logic        oc0b,
    output logic        irq
);
    logic [DATA_WIDTH-1:0] tccr0a, tccr0b, tcnt, timsk, tifr;
    logic [DATA_WIDTH-1:0] ocra, ocrb, ocra_buf, ocrb_buf;
    logic [DATA_WIDTH-1:0] ocra_nxt, ocrb_nxt;
    logic [DATA_WIDTH-1:0] tcnt_n, top, dout;
    logic [DATA_WIDTH-1:0] tifr_set, tifr_clr;
    logic [2:0]            wgm;
    mode_t                 mode;
    logic dir, dir_n, skip, tick, at_top, cnt_en, pwm, upd;
    logic match_a, match_b, wrap, tov;
    logic we_tccr0a, we_tccr0b, we_tcnt, we_ocra;
    logic we_ocrb, we_timsk, we_tifr;

    timer0_prescaler u_pres (
        .clk   (clk),
        .reset (reset),
        .cs    (tccr0b[2:0]),
        .tick  (tick)
    );

    assign wgm    = {tccr0b[3], tccr0a[1:0]};
    assign mode   = wgm_mode(wgm);
    assign top    = wgm_top_ocr(wgm) ? ocra : 8'hFF;
    assign pwm    = mode == MODE_FAST || mode == MODE_PC;
    assign at_top = tcnt == top;

    assign we_tccr0a = io.io_wr && io.io_addr == ADDR_TCCR0A;
    assign we_tccr0b = io.io_wr && io.io_addr == ADDR_TCCR0B;
    assign we_tcnt   = io.io_wr && io.io_addr == ADDR_TCNT0;
    assign we_ocra   = io.io_wr && io.io_addr == ADDR_OCR0A;
    assign we_ocrb   = io.io_wr && io.io_addr == ADDR_OCR0B;
    assign we_timsk  = io.io_wr && io.io_addr == ADDR_TIMSK0;
    assign we_tifr   = io.io_wr && io.io_addr == ADDR_TIFR0;

    assign ocra_nxt = we_ocra ? io.io_din : ocra_buf;
    assign ocrb_nxt = we_ocrb ? io.io_din : ocrb_buf;

    // A CPU write to TCNT0 overrides counting on that edge
    assign cnt_en  = tick && !we_tcnt;
    assign match_a = cnt_en && !skip && tcnt == ocra;
    assign match_b = cnt_en && !skip && tcnt == ocrb;
    assign wrap    = cnt_en && at_top && mode != MODE_PC;
    assign upd     = cnt_en && at_top && pwm;

    always_comb begin
        tov = 1'b0;
        unique case (mode)
            MODE_FAST: tov = cnt_en && at_top;
            MODE_PC:   tov = cnt_en && dir && tcnt == 8'd1;
            default:   tov = cnt_en && tcnt == 8'hFF;
        endcase
    end

    always_comb begin
        tcnt_n = tcnt;
        dir_n  = dir;
        if (mode == MODE_PC) begin
            if (!dir && at_top) begin
                tcnt_n = tcnt - 8'd1;
                dir_n  = 1'b1;
            end else if (dir && tcnt == 8'd0) begin
                tcnt_n = tcnt + 8'd1;
                dir_n  = 1'b0;
            end else if (dir) begin
                tcnt_n = tcnt - 8'd1;
            end else begin
                tcnt_n = tcnt + 8'd1;
            end
        end else begin
            tcnt_n = at_top ? 8'd0 : tcnt + 8'd1;
        end
    end

    always_comb begin
        tifr_set            = '0;
        tifr_set[BIT_TOV0]  = tov;
        tifr_set[BIT_OCF0A] = match_a;
        tifr_set[BIT_OCF0B] = match_b;
    end

    assign tifr_clr = we_tifr ? (io.io_din & 8'h07) : '0;
    assign irq      = |(tifr & timsk);

    always_comb begin
        dout = '0;
        if (io.io_rd) begin
            unique case (io.io_addr)
                ADDR_TCCR0A: dout = tccr0a;
                ADDR_TCCR0B: dout = tccr0b;
                ADDR_TCNT0:  dout = tcnt;
                ADDR_OCR0A:  dout = ocra_buf;
                ADDR_OCR0B:  dout = ocrb_buf;
                ADDR_TIMSK0: dout = timsk;
                ADDR_TIFR0:  dout = tifr;
                default:     dout = '0;
            endcase
        end
    end

    assign io.io_dout = dout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tccr0a   <= '0;
            tccr0b   <= '0;
            tcnt     <= '0;
            timsk    <= '0;
            tifr     <= '0;
            ocra     <= '0;
            ocrb     <= '0;
            ocra_buf <= '0;
            ocrb_buf <= '0;
            dir      <= 1'b0;
            skip     <= 1'b0;
            oc0a     <= 1'b0;
            oc0b     <= 1'b0;
        end else begin
            if (we_tccr0a) tccr0a <= io.io_din & 8'hF3;
            if (we_tccr0b) tccr0b <= io.io_din & 8'h0F;
            if (we_timsk)  timsk  <= io.io_din & 8'h07;
            // Set wins over a same-edge write-one clear
            tifr <= (tifr & ~tifr_clr) | tifr_set;
            if (we_tcnt) begin
                tcnt <= io.io_din;
            end else if (tick) begin
                tcnt <= tcnt_n;
                dir  <= dir_n;
            end
            if (we_tcnt)
                skip <= 1'b1;
            else if (tick)
                skip <= 1'b0;
            ocra_buf <= ocra_nxt;
            ocrb_buf <= ocrb_nxt;
            if (!pwm) begin
                ocra <= ocra_nxt;
                ocrb <= ocrb_nxt;
            end else if (upd) begin
                ocra <= ocra_buf;
                ocrb <= ocrb_buf;
            end
            oc0a <= oc_next(oc0a, tccr0a[7:6], mode,
                            match_a, wrap, dir);
            oc0b <= oc_next(oc0b, tccr0a[5:4], mode,
                            match_b, wrap, dir);
        end
    end
endmodule
